// File: rtl/riscv_pkg.sv
// riscv_pkg -- RV32I constants shared by the encode and decode paths.
//
// Contents:
//   R_TYPE .. JALR : 7-bit major opcodes accepted by the encoder
//   NOP            : canonical no-op (addi x0,x0,0) emitted for unknown opcodes
//   enc_state_e    : output-stage occupancy (EMPTY / FULL)
//   is_known_opcode: helper telling whether an opcode has an encoding rule
package riscv_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] I_LOAD = 7'b0000011;
  localparam logic [6:0] S_TYPE = 7'b0100011;
  localparam logic [6:0] B_TYPE = 7'b1100011;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } enc_state_e;

  function automatic logic is_known_opcode(input logic [6:0] op);
    logic known;
    case (op)
      R_TYPE, I_TYPE, I_LOAD, S_TYPE, B_TYPE,
      AUIPC, LUI, JAL, JALR: known = 1'b1;
      default:               known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// imm_pack -- combinational RV32I field assembler with immediate scatter.
//
// Ports:
//   i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_funct7 : instruction fields
//   i_imm    : byte-offset / value immediate (U-type: full value, [11:0] zero)
//   o_instr  : assembled instruction word (NOP for an unknown opcode)
//   o_err    : unknown opcode, or (IMM_RANGE_CHECK_EN) unrepresentable immediate
//
// Configuration: define IMM_RANGE_CHECK_EN to flag immediates that do not fit
// their format. Truncated bits are encoded either way.
module imm_pack
  import riscv_pkg::*;
(
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic [31:0] o_instr,
  output logic        o_err
);

`ifdef IMM_RANGE_CHECK_EN
  // An immediate fits N signed bits when every bit above N-1 copies bit N-1.
  logic w_fits12;
  logic w_fits13;
  logic w_fits21;
  logic w_low12_zero;

  assign w_fits12     = (i_imm[31:11] == {21{i_imm[11]}});
  assign w_fits13     = (i_imm[31:12] == {20{i_imm[12]}});
  assign w_fits21     = (i_imm[31:20] == {12{i_imm[20]}});
  assign w_low12_zero = (i_imm[11:0] == 12'h000);
`endif

  // Select the field layout for the opcode and scatter the immediate into it.
  always_comb begin
    o_instr = NOP;
    o_err   = 1'b0;
    case (i_opcode)
      R_TYPE: begin
        o_instr = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      end
      I_TYPE, I_LOAD, JALR: begin
        o_instr = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
`ifdef IMM_RANGE_CHECK_EN
        o_err   = ~w_fits12;
`endif
      end
      S_TYPE: begin
        o_instr = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
`ifdef IMM_RANGE_CHECK_EN
        o_err   = ~w_fits12;
`endif
      end
      B_TYPE: begin
        // Branch offsets are even, so imm[0] is dropped; imm[11] lands in bit 7.
        o_instr = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                   i_imm[4:1], i_imm[11], i_opcode};
`ifdef IMM_RANGE_CHECK_EN
        o_err   = ~w_fits13 | i_imm[0];
`endif
      end
      LUI, AUIPC: begin
        o_instr = {i_imm[31:12], i_rd, i_opcode};
`ifdef IMM_RANGE_CHECK_EN
        o_err   = ~w_low12_zero;
`endif
      end
      JAL: begin
        o_instr = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
`ifdef IMM_RANGE_CHECK_EN
        o_err   = ~w_fits21 | i_imm[0];
`endif
      end
      default: begin
        o_instr = NOP;
        o_err   = ~is_known_opcode(i_opcode);
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder -- one-deep registered RV32I instruction encoder.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input field-bundle handshake
//   opcode, rd, rs1, rs2, funct3, funct7, imm : instruction fields
//   out_valid / out_ready: output handshake
//   instr                : encoded instruction word (valid with out_valid)
//   enc_err              : unknown opcode or (with IMM_RANGE_CHECK_EN) bad immediate
//   enc_count            : accepted bundles, saturating at 16'hFFFF
//
// Configuration: IMM_RANGE_CHECK_EN (see imm_pack) enables immediate range errors.
//
// The output register is a single-entry pipeline stage: a result appears one
// cycle after acceptance, and in_ready also opens when the held word is being
// drained in the same cycle, so back-to-back traffic flows at one per cycle.
module instr_encoder
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        enc_err,
  output logic [15:0] enc_count
);

  enc_state_e  r_state;
  enc_state_e  w_state_nxt;
  logic [31:0] r_instr;
  logic        r_err;
  logic [15:0] r_count;
  logic [31:0] w_enc_instr;
  logic        w_enc_err;
  logic        w_accept;

  imm_pack u_imm_pack (
    .i_opcode (opcode),
    .i_rd     (rd),
    .i_rs1    (rs1),
    .i_rs2    (rs2),
    .i_funct3 (funct3),
    .i_funct7 (funct7),
    .i_imm    (imm),
    .o_instr  (w_enc_instr),
    .o_err    (w_enc_err)
  );

  assign out_valid = (r_state == ST_FULL);
  assign in_ready  = ~out_valid | out_ready;
  assign w_accept  = in_valid & in_ready;
  assign instr     = r_instr;
  assign enc_err   = r_err;
  assign enc_count = r_count;

  // Occupancy next-state: an accept always leaves the stage full.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_FULL;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_accept) begin
          w_state_nxt = ST_FULL;
        end else if (out_ready) begin
          w_state_nxt = ST_EMPTY;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output word and error flag; only an accept changes them, so they hold
  // through back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= 32'h0000_0000;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_instr <= w_enc_instr;
      r_err   <= w_enc_err;
    end else begin
      r_instr <= r_instr;
      r_err   <= r_err;
    end
  end

  // Saturating count of accepted bundles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 16'h0000;
    end else if (w_accept && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a behavioural model (arithmetic
// field packing plus a one-entry occupancy flag) is compared against the DUT on
// every falling clock edge; directed bundles pin literal encodings.
module tb_instr_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        enc_err;
  logic [15:0] enc_count;

  int checks = 0;
  int errors = 0;

  instr_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .enc_err   (enc_err),
    .enc_count (enc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding: returns {err, word}, built by shifting fields into place.
  function automatic logic [32:0] ref_enc(input logic [6:0] op, input logic [4:0] d,
                                          input logic [4:0] a, input logic [4:0] b,
                                          input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [31:0] im);
    logic [31:0] w;
    logic        e;
    logic [31:0] o3, d3, a3, b3, f33, f73;
`ifdef IMM_RANGE_CHECK_EN
    int s;
    s = $signed(im);
`endif
    o3 = 32'(op); d3 = 32'(d); a3 = 32'(a); b3 = 32'(b); f33 = 32'(f3); f73 = 32'(f7);
    e = 1'b0;
    case (op)
      7'h33: w = o3 | (d3 << 7) | (f33 << 12) | (a3 << 15) | (b3 << 20) | (f73 << 25);
      7'h13, 7'h03, 7'h67: begin
        w = o3 | (d3 << 7) | (f33 << 12) | (a3 << 15) | ((im & 32'hFFF) << 20);
`ifdef IMM_RANGE_CHECK_EN
        e = (s < -2048) || (s > 2047);
`endif
      end
      7'h23: begin
        w = o3 | ((im & 32'h1F) << 7) | (f33 << 12) | (a3 << 15) | (b3 << 20)
            | (((im >> 5) & 32'h7F) << 25);
`ifdef IMM_RANGE_CHECK_EN
        e = (s < -2048) || (s > 2047);
`endif
      end
      7'h63: begin
        w = o3 | (((im >> 11) & 32'h1) << 7) | (((im >> 1) & 32'hF) << 8) | (f33 << 12)
            | (a3 << 15) | (b3 << 20) | (((im >> 5) & 32'h3F) << 25)
            | (((im >> 12) & 32'h1) << 31);
`ifdef IMM_RANGE_CHECK_EN
        e = (s < -4096) || (s > 4095) || ((im & 32'h1) != 32'h0);
`endif
      end
      7'h37, 7'h17: begin
        w = (im & 32'hFFFF_F000) | (d3 << 7) | o3;
`ifdef IMM_RANGE_CHECK_EN
        e = ((im & 32'hFFF) != 32'h0);
`endif
      end
      7'h6F: begin
        w = o3 | (d3 << 7) | (((im >> 12) & 32'hFF) << 12) | (((im >> 11) & 32'h1) << 20)
            | (((im >> 1) & 32'h3FF) << 21) | (((im >> 20) & 32'h1) << 31);
`ifdef IMM_RANGE_CHECK_EN
        e = (s < -1048576) || (s > 1048575) || ((im & 32'h1) != 32'h0);
`endif
      end
      default: begin
        w = 32'h0000_0013;
        e = 1'b1;
      end
    endcase
    return {e, w};
  endfunction

  // Behavioural model of the output stage.
  logic        m_valid;
  logic [32:0] m_out;
  logic [15:0] m_cnt;
  logic        m_acc;

  assign m_acc = in_valid && (!m_valid || out_ready);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_out   <= 33'd0;
      m_cnt   <= 16'd0;
    end else if (m_acc) begin
      m_valid <= 1'b1;
      m_out   <= ref_enc(opcode, rd, rs1, rs2, funct3, funct7, imm);
      m_cnt   <= (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Compare process: DUT vs model on every falling edge.
  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    chk("enc_count", 32'(enc_count), 32'(m_cnt));
    if (m_valid) begin
      chk("instr", instr, m_out[31:0]);
      chk("enc_err", 32'(enc_err), 32'(m_out[32]));
    end
  end

  task automatic drive(input logic v, input logic rdy, input logic [6:0] op, input logic [4:0] d,
                       input logic [4:0] a, input logic [4:0] b, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] im);
    @(negedge clk);
    #2;
    in_valid = v; out_ready = rdy; opcode = op; rd = d; rs1 = a; rs2 = b;
    funct3 = f3; funct7 = f7; imm = im;
  endtask

  // Send one bundle into an empty/draining stage and check the literal result.
  task automatic send_lit(input string name, input logic [6:0] op, input logic [4:0] d,
                          input logic [4:0] a, input logic [4:0] b, input logic [2:0] f3,
                          input logic [31:0] im, input logic [31:0] exp_w, input logic exp_e);
    drive(1'b1, 1'b1, op, d, a, b, f3, 7'd0, im);
    @(posedge clk);
    #1;
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk(name, instr, exp_w);
    chk({name, "_err"}, 32'(enc_err), 32'(exp_e));
  endtask

  logic [32:0] pin;
  logic [15:0] cnt0;
  logic [6:0]  ops [10];

  initial begin
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    funct3 = 3'd0; funct7 = 7'd0; imm = 32'd0;

    // Pin the model itself against hand-encoded words.
    pin = ref_enc(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    chk("model_addi", pin[31:0], 32'h0050_0093);
    pin = ref_enc(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
    chk("model_beq", pin[31:0], 32'h0020_8463);
    pin = ref_enc(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    chk("model_jal", pin[31:0], 32'h0010_00EF);

    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_instr", instr, 32'd0);
    chk("rst_count", 32'(enc_count), 32'd0);
    #22 rst_n = 1'b1;
    #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    send_lit("addi", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 32'h0050_0093, 1'b0);
    send_lit("beq", 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd8, 32'h0020_8463, 1'b0);
    send_lit("sw", 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd4, 32'h0020_A223, 1'b0);
    send_lit("jal", 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 32'h0010_00EF, 1'b0);
    send_lit("lui", 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    send_lit("unknown", 7'h7F, 5'd3, 5'd4, 5'd5, 3'd1, 32'd7, 32'h0000_0013, 1'b1);
`ifdef IMM_RANGE_CHECK_EN
    send_lit("addi_2048", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 32'h8000_0093, 1'b1);
`else
    send_lit("addi_2048", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 32'h8000_0093, 1'b0);
`endif

    // Back-pressure: drain, load A, stall three cycles with B offered, release.
    drive(1'b0, 1'b1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    cnt0 = enc_count;
    drive(1'b1, 1'b0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 7'h33, 5'd7, 5'd8, 5'd9, 3'd0, 7'h20, 32'd0);
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_instr", instr, 32'h0050_0093);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 7'h13, 5'(i + 2), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
      #1;
      chk("release_in_ready", 32'(in_ready), 32'd1);
    end
    drive(1'b0, 1'b1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    chk("release_count", 32'(enc_count), 32'(cnt0 + 16'd4));

    // Asynchronous reset while FULL.
    drive(1'b1, 1'b0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_instr", instr, 32'd0);
    chk("async_rst_err", 32'(enc_err), 32'd0);
    chk("async_rst_count", 32'(enc_count), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    #12 rst_n = 1'b1;

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] r_im;
      case ($urandom_range(0, 3))
        0: r_im = $urandom;
        1: r_im = 32'($signed(12'($urandom)));
        2: r_im = {$urandom_range(0, 1) == 1 ? 11'h7FF : 11'h000, 21'($urandom)};
        default: r_im = {20'($urandom), 12'h000};
      endcase
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            ops[$urandom_range(0, 9)], 5'($urandom), 5'($urandom), 5'($urandom),
            3'($urandom), 7'($urandom), r_im);
      if (n == 700) begin
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
    end
    drive(1'b0, 1'b1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1: field bundle valid.
REQ-004 SHALL have port in_ready, output, 1: encoder can accept a bundle.
REQ-005 SHALL have ports opcode[6:0], rd[4:0], rs1[4:0], rs2[4:0], funct3[2:0] and funct7[6:0], all inputs: instruction fields.
REQ-006 SHALL have port imm, input, 32: byte-offset/value immediate; U-type carries the full 32-bit value with bits 11:0 zero.
REQ-007 SHALL have port out_valid, output, 1: instr is valid.
REQ-008 SHALL have port out_ready, input, 1: downstream accepts instr.
REQ-009 SHALL have port instr, output, 32: encoded RV32I instruction word.
REQ-010 SHALL have port enc_err, output, 1: flag accompanying instr; set for an unknown opcode or an out-of-range immediate.
REQ-011 SHALL have port enc_count, output, 16: number of accepted bundles, saturating.

Function
REQ-012 SHALL accept a bundle when in_valid && in_ready, and SHALL present the result on instr/out_valid one cycle later (latency 1).
REQ-013 SHALL drive in_ready = !out_valid || out_ready, so a simultaneous drain and fill sustains one bundle per cycle.
REQ-014 SHALL implement a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
- EMPTY->FULL on accept.
- FULL->EMPTY on out_ready without a new accept.
- FULL->FULL on out_ready with an accept, reloading instr.
REQ-015 SHALL hold instr, enc_err and out_valid stable while out_valid && !out_ready.
REQ-016 SHALL encode the bundle by opcode as follows:
- R (0110011): funct7|rs2|rs1|funct3|rd|op.
- I/LOAD/JALR (0010011/0000011/1100111): imm[11:0]|rs1|funct3|rd|op.
- S (0100011): imm[11:5]|rs2|rs1|funct3|imm[4:0]|op.
- B (1100011): imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op.
- LUI/AUIPC (0110111/0010111): imm[31:12]|rd|op.
- JAL (1101111): imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
REQ-017 SHALL output 32'h00000013 (NOP) with enc_err=1 for any other opcode.
REQ-018 SHALL increment enc_count by 1 on each accept and SHALL saturate at 16'hFFFF without wrapping.

Reset
REQ-019 SHALL, on rst_n=0 and regardless of clk or any transfer in progress, immediately drive out_valid=0, instr=32'h00000000, enc_err=0, enc_count=0 and FSM=EMPTY; any in-flight bundle is discarded.
REQ-020 SHALL drive in_ready=1 during reset and on the first cycle after release.

Configuration
REQ-021 SHALL use the macro IMM_RANGE_CHECK_EN to compile the immediate range check in or out.
REQ-022 SHALL, with IMM_RANGE_CHECK_EN defined, set enc_err for any of the following, while still encoding the truncated bits:
- I/S immediate that is not a sign-extended 12-bit value.
- B immediate that is not a sign-extended 13-bit value or has imm[0]=1.
- JAL immediate that is not a sign-extended 21-bit value or has imm[0]=1.
- U-type immediate with imm[11:0]!=0.
REQ-023 SHALL, without IMM_RANGE_CHECK_EN, truncate silently, with enc_err reflecting only an unknown opcode.

Structure
REQ-024 SHALL take the opcode constants (R_TYPE, I_TYPE, I_LOAD, S_TYPE, B_TYPE, AUIPC, LUI, JAL, JALR) and the NOP constant from the shared package riscv_pkg, which the decode-side immediate logic uses too.
REQ-025 SHALL place the combinational immediate scatter and range check in one sub-module, imm_pack; the handshake, FSM and counter SHALL live in instr_encoder.

Verification
REQ-026 SHALL cover addi x1,x0,5 (op 0010011, rd=1, imm=5) -> instr=0x00500093, enc_err=0, one cycle after accept.
REQ-027 SHALL cover beq x1,x2,+8 -> 0x00208463; sw x2,4(x1) -> 0x0020A223.
REQ-028 SHALL cover jal x1,+2048 -> 0x001000EF; lui x5 with imm=0x12345000 -> 0x123452B7.
REQ-029 SHALL cover out_ready=0 for 3 cycles with in_valid=1:
- instr held stable and in_ready=0.
- Release gives back-to-back transfers, one per cycle, and enc_count +1 per accept.
REQ-030 SHALL cover an unknown opcode 1111111 -> 0x00000013 with enc_err=1.
REQ-031 SHALL cover, under IMM_RANGE_CHECK_EN, addi with imm=2048 -> enc_err=1; and SHALL cover rst_n asserted while FULL -> out_valid=0 immediately.
